// File: rtl/thermostat_multistage_controller.sv
// Two-stage heat/cool thermostat controller with hysteresis, deadband,
// min-run, short-cycle lockout, stage-2 escalation and fan overrun.
module thermostat_multistage_controller #(
  parameter int g_sc_delay_time = 200,
  parameter int g_min_run_time  = 100,
  parameter int g_hyst          = 2,
  parameter int g_deadband      = 8,
  parameter int g_stage2_delta  = 8,
  parameter int g_stage2_delay  = 400,
  parameter int g_fan_overrun   = 60
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_sys_pwr_n,
  input  logic [1:0] i_mode,
  input  logic       i_fan_on,
  input  logic       i_temp_valid,
  input  logic [8:0] i_temperature,
  input  logic [8:0] i_heat_sp,
  input  logic [8:0] i_cool_sp,
  output logic       o_white_heat,
  output logic       o_white2_heat,
  output logic       o_yellow_ac,
  output logic       o_yellow2_ac,
  output logic       o_green_fan,
  output logic       o_cycling,
  output logic       o_band_err,
  output logic [2:0] o_state
);

  localparam int RUN_MAX = (g_min_run_time > g_stage2_delay) ?
                           g_min_run_time : g_stage2_delay;
  localparam int RW = $clog2(RUN_MAX) + 1;
  localparam int LW = $clog2(g_sc_delay_time) + 1;
  localparam int OW = $clog2(g_fan_overrun) + 1;

  localparam logic [RW-1:0] MIN_RUN   = RW'(g_min_run_time);
  localparam logic [RW-1:0] S2_DELAY  = RW'(g_stage2_delay);
  localparam logic [LW-1:0] LOCK_INIT = LW'(g_sc_delay_time - 1);
  localparam logic [OW-1:0] OVR_INIT  = OW'(g_fan_overrun);
  localparam logic [9:0]    HYST      = 10'(g_hyst);
  localparam logic [9:0]    DBAND     = 10'(g_deadband);
  localparam logic [9:0]    S2_DELTA  = 10'(g_stage2_delta);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HEAT1 = 3'd1,
    S_HEAT2 = 3'd2,
    S_COOL1 = 3'd3,
    S_COOL2 = 3'd4,
    S_LOCK  = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [8:0]    r_temp;
  logic          r_have_temp;
  logic          r_band_err;
  logic [RW-1:0] r_run;
  logic [LW-1:0] r_lock;
  logic [OW-1:0] r_ovr;

  logic [9:0] w_temp;
  logic [9:0] w_hsp;
  logic [9:0] w_csp;
  logic [9:0] w_heat_thr;
  logic [9:0] w_cool_sum;
  logic [9:0] w_cool_thr;
  logic w_en;
  logic w_band;
  logic w_heat_ok;
  logic w_cool_ok;
  logic w_heat_on;
  logic w_heat_sat;
  logic w_cool_on;
  logic w_cool_sat;
  logic w_heat_big;
  logic w_cool_big;
  logic w_run_met;
  logic w_heat_drop;
  logic w_cool_drop;
  logic w_active;

  assign w_temp = {1'b0, r_temp};
  assign w_hsp  = {1'b0, i_heat_sp};
  assign w_csp  = {1'b0, i_cool_sp};

  // Thresholds are clamped to the 9-bit range instead of wrapping
  assign w_heat_thr = (w_hsp >= HYST) ? (w_hsp - HYST) : 10'd0;
  assign w_cool_sum = w_csp + HYST;
  assign w_cool_thr = (w_cool_sum > 10'd511) ? 10'd511 : w_cool_sum;

  assign w_heat_on  = w_temp < w_heat_thr;
  assign w_heat_sat = w_temp >= w_hsp;
  assign w_cool_on  = w_temp > w_cool_thr;
  assign w_cool_sat = w_temp <= w_csp;
  assign w_heat_big = (w_hsp > w_temp) && ((w_hsp - w_temp) >= S2_DELTA);
  assign w_cool_big = (w_temp > w_csp) && ((w_temp - w_csp) >= S2_DELTA);

  assign w_en      = !i_sys_pwr_n && (i_mode != 2'b00);
  assign w_band    = (i_mode == 2'b11) && (w_csp < (w_hsp + DBAND));
  assign w_heat_ok = w_en && r_have_temp &&
                     ((i_mode == 2'b01) || ((i_mode == 2'b11) && !w_band));
  assign w_cool_ok = w_en && r_have_temp &&
                     ((i_mode == 2'b10) || ((i_mode == 2'b11) && !w_band));

  assign w_run_met   = r_run >= MIN_RUN;
  assign w_heat_drop = !w_en || ((w_heat_sat || !w_heat_ok) && w_run_met);
  assign w_cool_drop = !w_en || ((w_cool_sat || !w_cool_ok) && w_run_met);
  assign w_active    = (r_state == S_HEAT1) || (r_state == S_HEAT2) ||
                       (r_state == S_COOL1) || (r_state == S_COOL2);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_LOCK;
      r_temp      <= '0;
      r_have_temp <= 1'b0;
      r_band_err  <= 1'b0;
      r_run       <= '0;
      r_lock      <= LOCK_INIT;
      r_ovr       <= '0;
    end else begin
      r_state    <= w_next;
      r_band_err <= w_band;
      if (i_temp_valid) begin
        r_temp      <= i_temperature;
        r_have_temp <= 1'b1;
      end
      if (!w_active) r_run <= '0;
      else if (r_run != '1) r_run <= r_run + 1'b1;
      if ((w_next == S_LOCK) && (r_state != S_LOCK)) r_lock <= LOCK_INIT;
      else if ((r_state == S_LOCK) && (r_lock != '0)) r_lock <= r_lock - 1'b1;
      if (w_active && (w_next == S_LOCK)) r_ovr <= OVR_INIT;
      else if (r_ovr != '0) r_ovr <= r_ovr - 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_heat_ok && w_heat_on) w_next = S_HEAT1;
        else if (w_cool_ok && w_cool_on) w_next = S_COOL1;
      end
      S_HEAT1: begin
        if (w_heat_drop) w_next = S_LOCK;
        else if (w_heat_ok && (w_heat_big ||
                 ((r_run == S2_DELAY) && !w_heat_sat))) w_next = S_HEAT2;
      end
      S_HEAT2: if (w_heat_drop) w_next = S_LOCK;
      S_COOL1: begin
        if (w_cool_drop) w_next = S_LOCK;
        else if (w_cool_ok && (w_cool_big ||
                 ((r_run == S2_DELAY) && !w_cool_sat))) w_next = S_COOL2;
      end
      S_COOL2: if (w_cool_drop) w_next = S_LOCK;
      S_LOCK:  if (r_lock == '0) w_next = S_IDLE;
      default: w_next = S_LOCK;
    endcase
  end

  assign o_white_heat  = (r_state == S_HEAT1) || (r_state == S_HEAT2);
  assign o_white2_heat = r_state == S_HEAT2;
  assign o_yellow_ac   = (r_state == S_COOL1) || (r_state == S_COOL2);
  assign o_yellow2_ac  = r_state == S_COOL2;
  assign o_cycling     = r_state == S_LOCK;
  assign o_green_fan   = w_active || (i_fan_on && !i_sys_pwr_n) ||
                         (r_ovr != '0);
  assign o_band_err    = r_band_err;
  assign o_state       = r_state;

endmodule

// File: tb/tb_thermostat_multistage_controller.sv
// Directed bench for thermostat_multistage_controller (default parameters:
// lockout 200, min-run 100, stage-2 delay 400, fan overrun 60).
module tb_thermostat_multistage_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pwr_n;
  logic [1:0] mode;
  logic       fan_on;
  logic       valid;
  logic [8:0] temp;
  logic [8:0] heat_sp;
  logic [8:0] cool_sp;
  logic       white;
  logic       white2;
  logic       yellow;
  logic       yellow2;
  logic       fan;
  logic       cycling;
  logic       band_err;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] IDLE = 3'd0, HEAT1 = 3'd1, HEAT2 = 3'd2;
  localparam logic [2:0] COOL1 = 3'd3, LOCK = 3'd5;

  thermostat_multistage_controller dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_sys_pwr_n   (pwr_n),
    .i_mode        (mode),
    .i_fan_on      (fan_on),
    .i_temp_valid  (valid),
    .i_temperature (temp),
    .i_heat_sp     (heat_sp),
    .i_cool_sp     (cool_sp),
    .o_white_heat  (white),
    .o_white2_heat (white2),
    .o_yellow_ac   (yellow),
    .o_yellow2_ac  (yellow2),
    .o_green_fan   (fan),
    .o_cycling     (cycling),
    .o_band_err    (band_err),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [8:0] t);
    temp  = t;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    pwr_n   = 1'b0;
    mode    = 2'b01;
    fan_on  = 1'b0;
    valid   = 1'b0;
    temp    = 9'd0;
    heat_sp = 9'd312;
    cool_sp = 9'd400;
    repeat (2) tick();
    chk("rst_state", state, LOCK);
    chk("rst_cycling", cycling, 1);
    chk("rst_white", white, 0);
    chk("rst_fan", fan, 0);
    chk("rst_band", band_err, 0);

    // lockout after reset lasts exactly 200 cycles
    @(negedge clk) rst_n = 1'b1;
    strobe(9'd320);
    repeat (198) tick();
    chk("boot_lock199", state, LOCK);
    tick();
    chk("boot_idle200", state, IDLE);
    chk("boot_cyc0", cycling, 0);

    // heat stage 1, equality is no demand
    strobe(9'd316);
    strobe(9'd310);
    tick();
    chk("heat_eq_idle", state, IDLE);
    strobe(9'd309);
    chk("heat_lat1", state, IDLE);
    tick();
    chk("heat1_state", state, HEAT1);
    chk("heat1_white", white, 1);
    chk("heat1_white2", white2, 0);
    chk("heat1_fan", fan, 1);
    strobe(9'd312);
    repeat (99) tick();
    chk("minrun_hold", state, HEAT1);
    tick();
    chk("minrun_lock", state, LOCK);
    chk("minrun_white", white, 0);
    chk("minrun_cyc", cycling, 1);
    chk("ovr_fan_start", fan, 1);
    repeat (59) tick();
    chk("ovr_fan_59", fan, 1);
    tick();
    chk("ovr_fan_60", fan, 0);
    repeat (139) tick();
    chk("lock_199", state, LOCK);
    tick();
    chk("lock_200", state, IDLE);

    // large error forces stage 2 next cycle
    strobe(9'd303);
    chk("s2_lat", state, IDLE);
    tick();
    chk("s2_heat1", state, HEAT1);
    tick();
    chk("s2_heat2", state, HEAT2);
    chk("s2_white", white, 1);
    chk("s2_white2", white2, 1);

    // power off overrides min-run
    pwr_n = 1'b1;
    tick();
    pwr_n = 1'b0;
    chk("pwr_lock", state, LOCK);
    chk("pwr_white", white, 0);
    chk("pwr_white2", white2, 0);
    chk("pwr_fan", fan, 1);
    repeat (59) tick();
    chk("pwr_fan59", fan, 1);
    tick();
    chk("pwr_fan60", fan, 0);
    repeat (139) tick();
    chk("pwr_lock199", state, LOCK);
    tick();
    chk("pwr_idle", state, IDLE);

    // stage 2 by elapsed stage-1 run time
    strobe(9'd307);
    chk("dly_heat1", state, HEAT1);
    strobe(9'd310);
    repeat (399) tick();
    chk("dly_hold", white2, 0);
    chk("dly_hold_st", state, HEAT1);
    tick();
    chk("dly_heat2", state, HEAT2);
    chk("dly_white2", white2, 1);
    strobe(9'd312);
    tick();
    chk("dly_sat_lock", state, LOCK);
    chk("dly_sat_white", white, 0);

    // cool with min-run
    mode    = 2'b10;
    cool_sp = 9'd272;
    strobe(9'd270);
    repeat (199) tick();
    chk("cool_pre_idle", state, IDLE);
    strobe(9'd275);
    chk("cool_lat", state, IDLE);
    tick();
    chk("cool1_state", state, COOL1);
    chk("cool1_yellow", yellow, 1);
    chk("cool1_yellow2", yellow2, 0);
    repeat (9) tick();
    strobe(9'd270);
    repeat (90) tick();
    chk("cool_minrun_hold", yellow, 1);
    tick();
    chk("cool_minrun_lock", state, LOCK);
    chk("cool_yellow_off", yellow, 0);
    repeat (200) tick();
    chk("cool_idle", state, IDLE);

    // auto deadband blocks both directions
    mode    = 2'b11;
    heat_sp = 9'd288;
    cool_sp = 9'd290;
    tick();
    chk("band_err1", band_err, 1);
    repeat (5) tick();
    chk("band_no_heat", state, IDLE);
    strobe(9'd300);
    tick();
    chk("band_no_cool", state, IDLE);
    chk("band_no_yel", yellow, 0);
    cool_sp = 9'd300;
    tick();
    chk("band_err0", band_err, 0);
    strobe(9'd310);
    chk("auto_lat", state, IDLE);
    tick();
    chk("auto_cool1", state, COOL1);
    chk("auto_yellow", yellow, 1);

    // async reset mid-COOL1
    rst_n = 1'b0;
    #1;
    chk("arst_yellow", yellow, 0);
    chk("arst_fan", fan, 0);
    chk("arst_state", state, LOCK);
    chk("arst_cyc", cycling, 1);
    @(negedge clk) rst_n = 1'b1;
    repeat (199) tick();
    chk("arst_lock199", state, LOCK);
    tick();
    chk("arst_idle", state, IDLE);
    tick();
    chk("arst_notemp", state, IDLE);
    strobe(9'd310);
    chk("arst_lat", state, IDLE);
    tick();
    chk("arst_cool1", state, COOL1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/thermostat_multistage_controller.md
# thermostat_multistage_controller

Parametrised two-stage successor to the thermostat controller: drives heat stage 1/2, cool stage 1/2 and fan from a registered temperature sample and separate heat/cool setpoints, with hysteresis, auto-mode deadband checking, minimum-run and short-cycle lockout timers, stage-2 escalation and fan overrun. Sits between the SPI temperature path (spi_to_temp output plus a valid strobe) and the HVAC wire drivers, replacing the single-stage controller in multi-stage installs.

## Interface
- g_sc_delay_time, 200: short-cycle lockout length, clock cycles
- g_min_run_time, 100: minimum stage-on time, cycles
- g_hyst, 2: hysteresis, quarter-degree units (ufixed 7.2 LSBs)
- g_deadband, 8: minimum cool_sp − heat_sp in auto mode, LSBs
- g_stage2_delta, 8: error beyond setpoint that forces stage 2, LSBs
- g_stage2_delay, 400: stage-1 run time after which stage 2 engages if demand persists, cycles
- g_fan_overrun, 60: fan hold after a stage drops, cycles
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_sys_pwr_n  in  1  0 = system enabled
- i_mode  in  2  00 off, 01 heat, 10 cool, 11 auto
- i_fan_on  in  1  force fan
- i_temp_valid  in  1  one-cycle strobe, i_temperature valid
- i_temperature  in  9  ufixed 7.2 (unit selected upstream)
- i_heat_sp  in  9  heat setpoint, same format
- i_cool_sp  in  9  cool setpoint, same format
- o_white_heat, o_white2_heat  out  1 each  heat stage 1 / stage 2
- o_yellow_ac, o_yellow2_ac  out  1 each  cool stage 1 / stage 2
- o_green_fan  out  1  fan
- o_cycling  out  1  lockout active
- o_band_err  out  1  auto mode with cool_sp < heat_sp + g_deadband
- o_state  out  3  FSM state: 0 IDLE, 1 HEAT1, 2 HEAT2, 3 COOL1, 4 COOL2, 5 LOCKOUT

## Operation
- Temp register r_temp loads i_temperature on i_temp_valid; r_have_temp sets on first load. No demand until r_have_temp = 1.
- Thresholds in 10 bits, saturating: heat_on = r_temp < max(heat_sp − g_hyst, 0); heat_sat = r_temp ≥ heat_sp; cool_on = r_temp > min(cool_sp + g_hyst, 511); cool_sat = r_temp ≤ cool_sp. Exact equality with the on-threshold is no demand.
- Enable: en = !i_sys_pwr_n && i_mode != 00. Heat permitted in modes 01/11, cool in 10/11; auto with o_band_err = 1 permits neither.
- IDLE: heat permitted and heat_on → HEAT1; else cool permitted and cool_on → COOL1. Heat checked first.
- HEAT1/COOL1: run counter restarts on entry. Error ≥ g_stage2_delta beyond setpoint (heat_sp − r_temp, r_temp − cool_sp), or run counter = g_stage2_delay with demand not satisfied → HEAT2/COOL2.
- Any active state: (satisfied or direction no longer permitted) and run counter ≥ g_min_run_time → LOCKOUT. !en → LOCKOUT immediately, overriding min-run.
- HEAT2/COOL2 drop both stages together; no return to stage 1.
- LOCKOUT: counter loads g_sc_delay_time − 1 on entry and counts down; at 0 → IDLE. o_cycling = 1 only in LOCKOUT.
- Outputs decoded from the state register: HEAT1 → white; HEAT2 → white + white2; COOL1 → yellow; COOL2 → yellow + yellow2.
- Fan = active state, or i_fan_on && !i_sys_pwr_n, or overrun counter nonzero. Overrun loads g_fan_overrun on every active→LOCKOUT transition.
- Counter widths are $clog2 of the largest governing parameter plus 1. Counters saturate and never wrap.

## Timing
- Reset (async): state LOCKOUT, lockout counter = g_sc_delay_time − 1, o_cycling = 1, all HVAC outputs 0, o_band_err 0, r_have_temp 0, overrun 0. The first call after reset therefore waits ≥ g_sc_delay_time cycles.
- Latency: i_temp_valid at edge n → r_temp at edge n+1 → state and outputs change at edge n+2.
- o_band_err is registered, 1 cycle behind the inputs.
- Reset asserted mid-call drops every output within the same cycle (async).
- Setpoint or mode changes take effect at the next edge. They never bypass min-run except via !en.

## Test plan
- Heat: sp 78.0F (312), temps step down from 80F to 77.25F (309) → HEAT1 2 cycles after that strobe. At temp ≥ 312 and min-run met → LOCKOUT, o_cycling = 1 for exactly g_sc_delay_time cycles, fan held g_fan_overrun cycles.
- Stage 2: heat sp 312, temp 303 (delta 9) → HEAT1 then HEAT2 the next cycle. At temp 310, HEAT1 persists g_stage2_delay cycles → white2 asserts.
- Cool with min-run: cool sp 272, temp 275 → COOL1. Temp 270 after 10 cycles → yellow held until run = g_min_run_time, then LOCKOUT.
- Auto band: heat 288, cool 290 → o_band_err = 1, no stage ever asserts. Cool 300 → err 0, normal operation.
- Power off mid-HEAT2: i_sys_pwr_n = 1 → LOCKOUT next edge despite min-run, heat outputs 0, fan overrun runs.
- Reset mid-COOL1: all outputs 0 immediately. After release, o_state = LOCKOUT, and no stage asserts before g_sc_delay_time cycles plus a valid temperature sample.
